// File: rtl/bus_dma_master_pkg.sv
// Shared definitions for the bus DMA master: FSM encoding, strobe patterns and word size.
package bus_dma_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RD_GAP,
    ST_WR,
    ST_WR_GAP,
    ST_DONE
  } dma_state_t;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hF;
  localparam int unsigned WORD_BYTES = 4;

endpackage

// File: rtl/bus_dma_master_port.sv
// Single-transaction initiator: registers one request and holds it until m_ready.
// Optional wait timeout is built only when BUS_DMA_TIMEOUT_EN is defined.
module bus_master_port
  import bus_dma_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              launch,
  input  logic              is_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              xfer_done,
  output logic              timeout,
  output logic              m_select,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ready
);

  // A ready outside an active request (e.g. trailing into a gap) never counts.
  assign xfer_done = m_select && m_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_select <= 1'b0;
      m_wstrb  <= WSTRB_READ;
      m_addr   <= '0;
      m_wdata  <= '0;
    end else if (launch) begin
      m_select <= 1'b1;
      m_wstrb  <= is_write ? WSTRB_WORD : WSTRB_READ;
      m_addr   <= addr;
      m_wdata  <= wdata;
    end else if (xfer_done || timeout) begin
      m_select <= 1'b0;
    end
  end

`ifdef BUS_DMA_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (launch) begin
      wait_cnt <= '0;
    end else if (m_select && !m_ready) begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  // Fires on the last unacknowledged cycle so select is high exactly TIMEOUT_CYCLES cycles.
  assign timeout = m_select && !m_ready && (wait_cnt == LIMIT);
`else
  assign timeout = 1'b0;
`endif

endmodule

// File: rtl/bus_dma_master.sv
// Word-granular memory-to-memory copy engine on the picoRV peripheral bus.
// Optional feature macro: BUS_DMA_TIMEOUT_EN (bounded wait for m_ready, sets error).
module bus_dma_master
  import bus_dma_master_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              src_inc,
  input  logic              dst_inc,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              m_select,
  output logic [3:0]        m_wstrb,
  output logic [ADDR_W-1:0] m_addr,
  output logic [31:0]       m_wdata,
  input  logic              m_ready,
  input  logic [31:0]       m_rdata
);

  dma_state_t        state, state_d;
  logic [ADDR_W-1:0] src_cur, dst_cur, launch_addr;
  logic [CNT_W-1:0]  remaining;
  logic              src_inc_q, dst_inc_q;
  logic [31:0]       data_q;
  logic              launch, launch_write, accept, capture, advance;
  logic              xfer_done, timeout;

  always_comb begin
    state_d      = state;
    launch       = 1'b0;
    launch_write = 1'b0;
    launch_addr  = src_cur;
    accept       = 1'b0;
    capture      = 1'b0;
    advance      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept = 1'b1;
          if (count != '0) begin
            state_d     = ST_RD;
            launch      = 1'b1;
            launch_addr = src_addr;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_RD: begin
        if (xfer_done) begin
          capture = 1'b1;
          state_d = ST_RD_GAP;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_RD_GAP: begin
        state_d      = ST_WR;
        launch       = 1'b1;
        launch_write = 1'b1;
        launch_addr  = dst_cur;
      end
      ST_WR: begin
        if (xfer_done) begin
          advance = 1'b1;
          state_d = ST_WR_GAP;
        end else if (timeout) begin
          state_d = ST_DONE;
        end
      end
      ST_WR_GAP: begin
        if (remaining != '0) begin
          state_d = ST_RD;
          launch  = 1'b1;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/done are registered from the next state so they line up with the bus request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_d;
      busy  <= (state_d == ST_RD) || (state_d == ST_RD_GAP) ||
               (state_d == ST_WR) || (state_d == ST_WR_GAP);
      done  <= (state_d == ST_DONE);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      src_cur   <= '0;
      dst_cur   <= '0;
      remaining <= '0;
      src_inc_q <= 1'b0;
      dst_inc_q <= 1'b0;
      data_q    <= '0;
    end else begin
      if (accept) begin
        src_cur   <= src_addr;
        dst_cur   <= dst_addr;
        remaining <= count;
        src_inc_q <= src_inc;
        dst_inc_q <= dst_inc;
      end
      if (capture) data_q <= m_rdata;
      if (advance) begin
        remaining <= remaining - CNT_W'(1);
        src_cur   <= src_cur + (src_inc_q ? ADDR_W'(WORD_BYTES) : '0);
        dst_cur   <= dst_cur + (dst_inc_q ? ADDR_W'(WORD_BYTES) : '0);
      end
    end
  end

`ifdef BUS_DMA_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      error <= 1'b0;
    end else if (accept) begin
      error <= 1'b0;
    end else if (timeout) begin
      error <= 1'b1;
    end
  end
`else
  assign error = 1'b0;
`endif

  bus_master_port #(
    .ADDR_W         (ADDR_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_port (
    .clk       (clk),
    .reset_n   (reset_n),
    .launch    (launch),
    .is_write  (launch_write),
    .addr      (launch_addr),
    .wdata     (data_q),
    .xfer_done (xfer_done),
    .timeout   (timeout),
    .m_select  (m_select),
    .m_wstrb   (m_wstrb),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_ready   (m_ready)
  );

endmodule

// File: tb/tb_bus_dma_master.sv
// Directed, table-driven bench for bus_dma_master with a small memory responder model.
module tb_bus_dma_master;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src_addr = '0, dst_addr = '0;
  logic [15:0] count = '0;
  logic        src_inc = 1'b0, dst_inc = 1'b0;
  logic        busy, done, error;
  logic        m_select;
  logic [3:0]  m_wstrb;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic        m_ready;

  always #5 clk = ~clk;

  bus_dma_master #(.ADDR_W(32), .CNT_W(16), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .count(count), .src_inc(src_inc), .dst_inc(dst_inc), .busy(busy), .done(done),
    .error(error), .m_select(m_select), .m_wstrb(m_wstrb), .m_addr(m_addr),
    .m_wdata(m_wdata), .m_ready(m_ready), .m_rdata(m_rdata)
  );

  function automatic logic [31:0] pat(input logic [9:0] idx);
    return 32'hA500_0000 + 32'(idx) * 32'h0001_0003;
  endfunction

  // Read-only memory image; the DUT's writes are logged, not stored.
  logic [31:0] mem [0:1023];
  initial for (int i = 0; i < 1024; i++) mem[i] = pat(10'(i));
  assign m_rdata = mem[m_addr[11:2]];

  // Responder modes: 0 = ack after ws wait cycles, 1 = ready follows select (trailing ready), 2 = never ack.
  int resp_mode = 0;
  int ws = 0;
  int wcnt;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_ready <= 1'b0;
      wcnt    <= 0;
    end else if (resp_mode == 1) begin
      m_ready <= m_select;
    end else if (resp_mode == 2) begin
      m_ready <= 1'b0;
    end else if (m_select && !m_ready) begin
      if (wcnt == ws) begin
        m_ready <= 1'b1;
        wcnt    <= 0;
      end else begin
        wcnt <= wcnt + 1;
      end
    end else begin
      m_ready <= 1'b0;
      wcnt    <= 0;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] rd_q[$], wr_a_q[$], wr_d_q[$];
  int sel_rises = 0, sel_hi = 0, stab_err = 0, busy_hi = 0, done_cnt = 0;
  int busy_rise_cyc = 0, done_cyc = 0;
  logic err_at_done = 1'b0;
  logic prev_sel = 1'b0, prev_ready = 1'b0, prev_busy = 1'b0;
  logic [3:0] prev_wstrb = '0;
  logic [31:0] prev_addr = '0, prev_wdata = '0;

  always @(negedge clk) begin
    if (m_select && m_ready) begin
      if (m_wstrb == 4'hF) begin
        wr_a_q.push_back(m_addr);
        wr_d_q.push_back(m_wdata);
      end else begin
        rd_q.push_back(m_addr);
      end
    end
    if (m_select && !prev_sel) sel_rises++;
    if (m_select) sel_hi++;
    if (m_select && prev_sel && !prev_ready &&
        (m_addr !== prev_addr || m_wstrb !== prev_wstrb || m_wdata !== prev_wdata)) stab_err++;
    if (busy) busy_hi++;
    if (busy && !prev_busy) busy_rise_cyc = cyc;
    if (done) begin
      done_cnt++;
      done_cyc    = cyc;
      err_at_done = error;
    end
    prev_sel   = m_select;
    prev_ready = m_ready;
    prev_busy  = busy;
    prev_wstrb = m_wstrb;
    prev_addr  = m_addr;
    prev_wdata = m_wdata;
  end

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string nm);
    chk({nm, " m_select"}, 32'(m_select), 32'd0);
    chk({nm, " m_wstrb"}, 32'(m_wstrb), 32'd0);
    chk({nm, " m_addr"}, m_addr, 32'd0);
    chk({nm, " m_wdata"}, m_wdata, 32'd0);
    chk({nm, " busy"}, 32'(busy), 32'd0);
    chk({nm, " done"}, 32'(done), 32'd0);
    chk({nm, " error"}, 32'(error), 32'd0);
  endtask

  task automatic run_job(input logic [31:0] s, input logic [31:0] d, input int n,
                         input logic si, input logic di, input int budget, output int t_edge);
    int base;
    bit ok;
    base = done_cnt;
    @(posedge clk); #1;
    src_addr = s; dst_addr = d; count = 16'(n); src_inc = si; dst_inc = di; start = 1'b1;
    @(posedge clk); #1;
    start  = 1'b0;
    t_edge = cyc;
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk); #1;
      if (done_cnt != base) begin
        ok = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL done_wait: no done pulse within %0d cycles, required one", budget);
    end
  endtask

  task automatic check_job(input string nm, input logic [31:0] s, input logic [31:0] d,
                           input int n, input logic si, input logic di, input int exp_cyc,
                           input int rb, input int wb, input int sb, input int stb);
    logic [31:0] ea, ed;
    int nw, nr;
    nw = wr_a_q.size() - wb;
    nr = rd_q.size() - rb;
    chk({nm, " cycles"}, 32'(done_cyc - busy_rise_cyc), 32'(exp_cyc));
    chk({nm, " writes"}, 32'(nw), 32'(n));
    chk({nm, " reads"}, 32'(nr), 32'(n));
    chk({nm, " sel_rises"}, 32'(sel_rises - sb), 32'(2 * n));
    chk({nm, " stable"}, 32'(stab_err - stb), 32'd0);
    chk({nm, " error"}, 32'(err_at_done), 32'd0);
    for (int i = 0; i < n && i < nw && i < nr; i++) begin
      ea = s + (si ? 32'(4 * i) : 32'd0);
      ed = d + (di ? 32'(4 * i) : 32'd0);
      chk($sformatf("%s rd_addr[%0d]", nm, i), rd_q[rb + i], ea);
      chk($sformatf("%s wr_addr[%0d]", nm, i), wr_a_q[wb + i], ed);
      chk($sformatf("%s wr_data[%0d]", nm, i), wr_d_q[wb + i], pat(ea[11:2]));
    end
  endtask

  typedef struct {
    logic [31:0] src;
    logic [31:0] dst;
    int          cnt;
    logic        si;
    logic        di;
    int          ws;
    int          mode;
    int          exp_cycles;
    logic [31:0] exp_last_rd;
    logic [31:0] exp_last_wr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int t, rb, wb, sb, stb, db, bb, nw;
    bit found;

    vecs[0] = '{32'h0000_0100, 32'h0000_0200, 3, 1'b1, 1'b1, 0, 0, 18, 32'h0000_0108, 32'h0000_0208};
    vecs[1] = '{32'h0000_0140, 32'h0000_0004, 4, 1'b1, 1'b0, 0, 0, 24, 32'h0000_014C, 32'h0000_0004};
    vecs[2] = '{32'h0000_0180, 32'h0000_0300, 2, 1'b1, 1'b1, 5, 0, 32, 32'h0000_0184, 32'h0000_0304};
    vecs[3] = '{32'h0000_01C0, 32'h0000_0380, 3, 1'b1, 1'b1, 0, 1, 18, 32'h0000_01C8, 32'h0000_0388};
    vecs[4] = '{32'h0000_01F0, 32'h0000_03C0, 2, 1'b0, 1'b1, 0, 0, 12, 32'h0000_01F0, 32'h0000_03C4};
    vecs[5] = '{32'hFFFF_FFFC, 32'h0000_0240, 2, 1'b1, 1'b1, 0, 0, 12, 32'h0000_0000, 32'h0000_0244};

    repeat (3) @(negedge clk);
    #1 chk_outputs_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    for (int v = 0; v < 6; v++) begin
      resp_mode = vecs[v].mode;
      ws        = vecs[v].ws;
      rb = rd_q.size(); wb = wr_a_q.size(); sb = sel_rises; stb = stab_err;
      run_job(vecs[v].src, vecs[v].dst, vecs[v].cnt, vecs[v].si, vecs[v].di, 400, t);
      check_job($sformatf("vec%0d", v), vecs[v].src, vecs[v].dst, vecs[v].cnt,
                vecs[v].si, vecs[v].di, vecs[v].exp_cycles, rb, wb, sb, stb);
      if (rd_q.size() >= rb + vecs[v].cnt && wr_a_q.size() >= wb + vecs[v].cnt) begin
        chk($sformatf("vec%0d last_rd", v), rd_q[rb + vecs[v].cnt - 1], vecs[v].exp_last_rd);
        chk($sformatf("vec%0d last_wr", v), wr_a_q[wb + vecs[v].cnt - 1], vecs[v].exp_last_wr);
      end
    end

    resp_mode = 0; ws = 0;
    bb = busy_hi; sb = sel_rises;
    run_job(32'h100, 32'h200, 0, 1'b1, 1'b1, 10, t);
    chk("cnt0 done_cycle", 32'(done_cyc), 32'(t));
    chk("cnt0 busy", 32'(busy_hi - bb), 32'd0);
    chk("cnt0 select", 32'(sel_rises - sb), 32'd0);
    chk("cnt0 error", 32'(err_at_done), 32'd0);

`ifdef BUS_DMA_TIMEOUT_EN
    resp_mode = 2;
    sb = sel_hi; wb = wr_a_q.size();
    run_job(32'h100, 32'h200, 3, 1'b1, 1'b1, 100, t);
    chk("tmo sel_cycles", 32'(sel_hi - sb), 32'd8);
    chk("tmo err_at_done", 32'(err_at_done), 32'd1);
    chk("tmo done_cycle", 32'(done_cyc), 32'(t + 8));
    chk("tmo writes", 32'(wr_a_q.size() - wb), 32'd0);
    @(negedge clk); #1;
    chk("tmo error_sticky", 32'(error), 32'd1);
    chk("tmo select", 32'(m_select), 32'd0);
    resp_mode = 0;
    wb = wr_a_q.size();
    run_job(32'h120, 32'h220, 1, 1'b1, 1'b1, 100, t);
    chk("tmo clear err", 32'(err_at_done), 32'd0);
    chk("tmo clear writes", 32'(wr_a_q.size() - wb), 32'd1);
`else
    resp_mode = 2;
    db = done_cnt;
    @(posedge clk); #1;
    src_addr = 32'h300; dst_addr = 32'h200; count = 16'd1; src_inc = 1'b1; dst_inc = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    chk("hold select", 32'(m_select), 32'd1);
    chk("hold addr", m_addr, 32'h300);
    chk("hold wstrb", 32'(m_wstrb), 32'd0);
    chk("hold busy", 32'(busy), 32'd1);
    chk("hold no_done", 32'(done_cnt - db), 32'd0);
    chk("hold error", 32'(error), 32'd0);
    reset_n = 1'b0;
    @(negedge clk) reset_n = 1'b1;
    resp_mode = 0;
`endif

    db = done_cnt;
    @(posedge clk); #1;
    src_addr = 32'h100; dst_addr = 32'h200; count = 16'd5; src_inc = 1'b1; dst_inc = 1'b1; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #2;
      if (m_select && m_wstrb == 4'hF && m_addr == 32'h204 && !m_ready) begin
        found = 1'b1;
        break;
      end
    end
    chk("midrst found_wr2", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1 chk_outputs_zero("midrst");
    repeat (3) @(negedge clk);
    chk("midrst no_done", 32'(done_cnt - db), 32'd0);
    @(negedge clk) reset_n = 1'b1;

    rb = rd_q.size(); wb = wr_a_q.size(); sb = sel_rises; stb = stab_err;
    nw = 5;
    run_job(32'h100, 32'h200, nw, 1'b1, 1'b1, 400, t);
    check_job("post_rst", 32'h100, 32'h200, nw, 1'b1, 1'b1, 30, rb, wb, sb, stb);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_dma_master.md
# bus_dma_master

Word-granular memory-to-memory copy engine that acts as the initiator on the picoRV peripheral bus (select / wstrb / addr / data / ready). It is started from a control interface, reads `count` words from a source address and writes each one to a destination address, one bus transaction at a time. It sits beside the CPU behind the bus arbiter and drives peripherals such as the GPIO block, for example by streaming a pattern into its output register.

## Interface
Parameters:
- `ADDR_W`, 32: address width of `m_addr`, `src_addr` and `dst_addr`.
- `CNT_W`, 16: width of `count`.
- `TIMEOUT_CYCLES`, 255: maximum number of cycles to wait for `m_ready`. Used only with `BUS_DMA_TIMEOUT_EN`.

Ports:
- `clk` in 1: clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request. Sampled only in IDLE.
- `src_addr` in ADDR_W: first source word address. Must be 4-byte aligned.
- `dst_addr` in ADDR_W: first destination word address. Must be 4-byte aligned.
- `count` in CNT_W: number of words to copy.
- `src_inc` in 1: 1 = add 4 to the source address after each word; 0 = keep the source address fixed.
- `dst_inc` in 1: same as `src_inc`, applied to the destination address.
- `busy` out 1: high from the cycle after an accepted `start` through the final gap cycle.
- `done` out 1: one-cycle pulse at the end of a job. Pulses on success and on abort.
- `error` out 1: sticky timeout flag. Cleared by an accepted `start`.
- `m_select` out 1: bus request.
- `m_wstrb` out 4: 4'b0000 for a read, 4'b1111 for a write.
- `m_addr` out ADDR_W: bus address.
- `m_wdata` out 32: write data.
- `m_ready` in 1: responder acknowledge.
- `m_rdata` in 32: read data. Valid when `m_ready` is high.

## Operation
- `start` with `busy` high is ignored.
- On `start` in IDLE, the engine latches `src_addr`, `dst_addr`, `count`, `src_inc` and `dst_inc` and clears `error`.
- FSM states: IDLE, RD, RD_GAP, WR, WR_GAP, DONE.
- IDLE -> RD on `start` when count is non-zero.
- IDLE -> DONE on `start` when count = 0. No bus traffic occurs.
- RD: `m_select`=1, `m_wstrb`=0, `m_addr`=current source address. Stays until `m_ready`=1. On that edge the engine captures `m_rdata` into the data register and moves to RD_GAP.
- RD_GAP: `m_select`=0 for one cycle. Any `m_ready` seen here is ignored. Next state WR.
- WR: `m_select`=1, `m_wstrb`=4'hF, `m_addr`=current destination address, `m_wdata`=data register. Stays until `m_ready`=1. On that edge the remaining count is decremented, each address is advanced by 4 if its inc flag is set, and the FSM moves to WR_GAP.
- WR_GAP: one idle cycle. Next state RD if the remaining count is non-zero, otherwise DONE.
- DONE: `done`=1 for one cycle. Next state IDLE.
- Address arithmetic is modulo 2^ADDR_W. An increment past the top of the address space wraps to 0 silently.
- The gap cycles are mandatory. A responder that acknowledges on every cycle `select` is high raises a trailing `ready` after the request drops, and the gap absorbs it.
- Reset, including mid-transfer, returns the FSM to IDLE and clears all outputs, the counters and the data register. No `done` pulse is produced.

## Timing
- All outputs are registered.
- Reset values: `m_select`=0, `m_wstrb`=0, `m_addr`=0, `m_wdata`=0, `busy`=0, `done`=0, `error`=0.
- `start` at edge T: `busy`=1 and the RD request are visible in cycle T+1.
- With a responder that acknowledges one cycle after select, each word takes 6 cycles (RD 2, RD_GAP 1, WR 2, WR_GAP 1).
- `done` pulses in the cycle after the last WR_GAP. `busy` falls in the same cycle as the `done` pulse.
- With count = 0, `done` pulses in cycle T+1 and `busy` stays low.
- Wait states are unbounded: select and address are held steady until `m_ready`.

## Configuration
- `BUS_DMA_TIMEOUT_EN` defined: a wait counter is cleared on entry to RD or WR and increments every cycle without `m_ready`. When it reaches `TIMEOUT_CYCLES`, the engine sets `error`, drops select, moves to DONE and pulses `done`. Remaining words are abandoned.
- `BUS_DMA_TIMEOUT_EN` undefined: no counter is built, `error` is tied to 0, and the engine waits indefinitely for `m_ready`.

## Structure
- Shared package holds:
  - the FSM state encoding;
  - `WSTRB_READ` = 4'h0 and `WSTRB_WORD` = 4'hF;
  - `WORD_BYTES` = 4.
- One sub-module: `bus_master_port`. It performs a single transaction (request/hold-until-ready/gap) and includes the optional timeout. `bus_dma_master` sequences it.

## Test plan
- Copy 3 words from src 0x100 to dst 0x200, both inc=1, memory model acking after 1 cycle -> reads at 0x100/0x104/0x108, writes of identical data at 0x200/0x204/0x208, 18 cycles from busy to done.
- count=0 -> done pulse in cycle T+1, no `m_select` assertion, `error`=0.
- Copy 4 words with dst_inc=0, dst 0x04 (GPIO out register) -> four writes all to 0x04, in order, with the source data; source addresses advance by 4.
- Responder adds 5 wait states per access -> select and address held stable throughout, data intact. Also check that a trailing `ready` in the gap cycle causes no extra transaction.
- With `BUS_DMA_TIMEOUT_EN` and TIMEOUT_CYCLES=8, responder never acks -> after 8 cycles select drops, `error`=1 and `done` pulses. A new start clears `error`.
- Assert reset_n low during the second WR of a 5-word job -> all outputs 0 immediately, no done pulse. A fresh start after reset runs the full job.
